weights_dot_engine: RTL and testbench
=====================================

Name: weights_dot_engine

Overview:
Neuron dot-product engine that sits directly downstream of the weights register bank, acting as the bank's read master. On each start it streams row_count weight rows from consecutive bank addresses and multiplies each row's 3 signed weights by a 3-pixel input beat. It accumulates the products into a signed sum and reports the result and its sign (cat / not-cat decision) to the controlling CPU logic.

Parameters:
Amba_Addr_Depth, 12, bank address MSB index; address ports are Amba_Addr_Depth+1 bits wide.
WeightPrecision, 5, bits per signed weight; supported values are 5, 8 and 16.
WeightRowWidth, 15, 3*WeightPrecision; the width of one bank row.
AccWidth, 32, accumulator and result width.

Ports:
clock  in  1  single clock; all state updates on its rising edge.
reset  in  1  asynchronous, active-low reset.
start  in  1  one-cycle request; honoured only in IDLE.
base_addr  in  Amba_Addr_Depth+1  first bank row address, captured on an accepted start.
row_count  in  Amba_Addr_Depth+1  number of rows to process, captured on an accepted start.
busy  out  1  high in every state except IDLE.
pix_valid  in  1  pixel beat valid.
pix_ready  out  1  engine accepts a pixel beat.
pix_data  in  24  three unsigned 8-bit pixels: p0 in [7:0], p1 in [15:8], p2 in [23:16].
wb_control  out  2  bank control: 2'b10 = READ, 2'b00 = idle; WRITE (2'b01) is never driven.
wb_address  out  Amba_Addr_Depth+1  bank row address.
wb_read_data  in  WeightRowWidth  bank read data.
result  out  AccWidth  signed accumulated sum.
result_valid  out  1  one-cycle pulse when result is final.
cat_detect  out  1  1 when the final result is greater than 0.

Behaviour:
- Reset (asynchronous, active-low):
  - State goes to IDLE.
  - wb_control=00, wb_address=0, pix_ready=0, busy=0.
  - result=0, result_valid=0, cat_detect=0.
  - Applies immediately mid-operation: any in-flight read and any partial sum are discarded.
- Bank timing contract: READ is driven in cycle t. The bank registers the row at edge t, and wb_read_data is valid only during cycle t+1. At all other times it may be z.
- Row packing: w0 in [WP-1:0], w1 in [2WP-1:WP], w2 in [3WP-1:2WP], each two's-complement.
- States:
  - IDLE:
    - start=1 latches base_addr into addr_q and row_count into rows_q, clears acc, and goes to ISSUE.
    - If row_count=0, go to DONE instead, with acc=0.
    - start while not IDLE is ignored.
  - ISSUE: wb_control=10, wb_address=addr_q, then go to CAPTURE.
  - CAPTURE: wb_control=00; wb_read_data is latched into row_q, then go to PIX.
  - PIX:
    - pix_ready=1; the engine waits indefinitely for pix_valid.
    - On pix_valid & pix_ready, register the sum of the three products wi*{1'b0,pi}.
    - Each product is (WP+9)-bit signed; the 3-term sum is (WP+11)-bit, sign-extended to AccWidth.
    - Then go to ACC.
  - ACC:
    - acc <= acc + sum, using two's-complement wrap-around (no saturation).
    - Decrement rows_q. addr_q <= addr_q+1, wrapping modulo 2^(Amba_Addr_Depth+1).
    - If rows_q was 1, go to DONE; otherwise go to ISSUE.
  - DONE:
    - result <= acc; cat_detect <= (acc > 0, signed); result_valid=1 for exactly this cycle.
    - Then go to IDLE.
    - result and cat_detect hold until the next DONE or reset.
- Throughput: 4 cycles per row plus pixel stall cycles. Latency from start to result_valid is 4*N+2 cycles with zero stalls.
- pix_ready is 0 outside PIX. pix_data is sampled only at the handshake edge.
- A start pulse arriving on the same cycle as DONE is ignored.

Decomposition:
- Shared package:
  - bank control constants READ=2'b10, WRITE=2'b01, NOP=2'b00;
  - state enum (IDLE, ISSUE, CAPTURE, PIX, ACC, DONE);
  - width functions for product and sum (WP+9, WP+11).
- Sub-module weight_row_mac:
  - combinational;
  - unpacks the row, performs the 3 signed-by-unsigned multiplies, and produces the sign-extended 3-term sum;
  - parameterised by WeightPrecision and AccWidth.

Test Plan:
1. WP=5, bank[0]=0x07C3 (w0=3, w1=-2, w2=1), start with base 0, count 1, pix p0=10 p1=20 p2=30 -> result=20, cat_detect=1, result_valid pulses 1 cycle, latency 6 cycles.
2. count 3 from base 0x1FFE (wrap at 2^13) -> wb_address sequence 0x1FFE, 0x1FFF, 0x0000; READ is high exactly 1 cycle per row.
3. Row with all weights -16, pixels 255,255,255 -> sum -12240; result=-12240 (0xFFFFD030), cat_detect=0.
4. pix_valid held low 7 cycles in PIX -> pix_ready stays 1, no state advance; result is identical to the no-stall run.
5. count=0 -> result_valid 2 cycles after start, result=0, cat_detect=0, no READ issued.
6. reset asserted during PIX of row 2 of 4 -> all outputs 0 immediately; a following start with count 1 computes from a clean accumulator; a start pulse while busy has no effect.

Source files
------------

// File: rtl/weights_dot_engine_pkg.sv
// Shared definitions for the weights dot-product engine: bank control codes,
// controller states and the product/sum width rules.
package weights_dot_engine_pkg;

    localparam logic [1:0] BANK_READ  = 2'b10;
    localparam logic [1:0] BANK_WRITE = 2'b01;
    localparam logic [1:0] BANK_NOP   = 2'b00;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        CAPTURE,
        PIX,
        ACC,
        DONE
    } state_t;

    // A signed weight times a zero-extended 8-bit pixel needs WP+9 bits;
    // three such products need two more bits of headroom.
    function automatic int prodWidth(input int wp);
        return wp + 9;
    endfunction

    function automatic int sumWidth(input int wp);
        return wp + 11;
    endfunction

endpackage

// File: rtl/weight_row_mac.sv
// Combinational multiply-accumulate of one packed weight row against three
// unsigned pixels, producing a sign-extended 3-term sum.
module weight_row_mac
    import weights_dot_engine_pkg::*;
#(
    parameter int WeightPrecision = 5,
    parameter int AccWidth        = 32
) (
    input  logic [3*WeightPrecision-1:0] i_row,
    input  logic [23:0]                  i_pixels,
    output logic [AccWidth-1:0]          o_sum
);

    localparam int WP = WeightPrecision;
    localparam int PW = prodWidth(WP);
    localparam int SW = sumWidth(WP);

    logic [PW-1:0] w_prod [3];
    logic [SW-1:0] w_sum;

    // Both operands are widened to the product width, so the truncated
    // unsigned multiply yields the exact two's-complement product.
    always_comb begin
        for (int k = 0; k < 3; k++) begin
            w_prod[k] = {{9{i_row[k*WP+WP-1]}}, i_row[k*WP +: WP]}
                      * {{(WP+1){1'b0}}, i_pixels[k*8 +: 8]};
        end
    end

    assign w_sum = {{2{w_prod[0][PW-1]}}, w_prod[0]}
                 + {{2{w_prod[1][PW-1]}}, w_prod[1]}
                 + {{2{w_prod[2][PW-1]}}, w_prod[2]};

    assign o_sum = {{(AccWidth-SW){w_sum[SW-1]}}, w_sum};

endmodule

// File: rtl/weights_dot_engine.sv
// Neuron dot-product engine: reads weight rows from the weights bank, pairs
// each with a pixel beat and reports the signed sum and cat/not-cat decision.
module weights_dot_engine
    import weights_dot_engine_pkg::*;
#(
    parameter int Amba_Addr_Depth = 12,
    parameter int WeightPrecision = 5,
    parameter int WeightRowWidth  = 3*WeightPrecision,
    parameter int AccWidth        = 32
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      start,
    input  logic [Amba_Addr_Depth:0]  base_addr,
    input  logic [Amba_Addr_Depth:0]  row_count,
    output logic                      busy,
    input  logic                      pix_valid,
    output logic                      pix_ready,
    input  logic [23:0]               pix_data,
    output logic [1:0]                wb_control,
    output logic [Amba_Addr_Depth:0]  wb_address,
    input  logic [WeightRowWidth-1:0] wb_read_data,
    output logic [AccWidth-1:0]       result,
    output logic                      result_valid,
    output logic                      cat_detect
);

    localparam int AW = Amba_Addr_Depth + 1;
    localparam logic [AW-1:0] ADDR_ONE = {{(AW-1){1'b0}}, 1'b1};

    state_t                    r_state;
    state_t                    w_nextState;
    logic [AW-1:0]             r_addr;
    logic [AW-1:0]             r_rows;
    logic [WeightRowWidth-1:0] r_row;
    logic [AccWidth-1:0]       r_sum;
    logic [AccWidth-1:0]       r_acc;
    logic [AccWidth-1:0]       r_result;
    logic                      r_resultValid;
    logic                      r_cat;
    logic [AccWidth-1:0]       w_macSum;

    weight_row_mac #(
        .WeightPrecision (WeightPrecision),
        .AccWidth        (AccWidth)
    ) u_mac (
        .i_row    (r_row),
        .i_pixels (pix_data),
        .o_sum    (w_macSum)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state       <= IDLE;
            r_addr        <= '0;
            r_rows        <= '0;
            r_row         <= '0;
            r_sum         <= '0;
            r_acc         <= '0;
            r_result      <= '0;
            r_resultValid <= 1'b0;
            r_cat         <= 1'b0;
        end else begin
            r_state       <= w_nextState;
            r_resultValid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_addr <= base_addr;
                        r_rows <= row_count;
                        r_acc  <= '0;
                    end
                end
                CAPTURE: r_row <= wb_read_data;
                PIX: begin
                    if (pix_valid) begin
                        r_sum <= w_macSum;
                    end
                end
                ACC: begin
                    r_acc  <= r_acc + r_sum;
                    r_rows <= r_rows - ADDR_ONE;
                    r_addr <= r_addr + ADDR_ONE;
                end
                DONE: begin
                    // Result and its valid strobe appear together one cycle later.
                    r_result      <= r_acc;
                    r_cat         <= !r_acc[AccWidth-1] && (r_acc != '0);
                    r_resultValid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_nextState = r_state;
        wb_control  = BANK_NOP;
        wb_address  = '0;
        pix_ready   = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_nextState = (row_count == '0) ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                wb_control  = BANK_READ;
                wb_address  = r_addr;
                w_nextState = CAPTURE;
            end
            CAPTURE: w_nextState = PIX;
            PIX: begin
                pix_ready = 1'b1;
                if (pix_valid) begin
                    w_nextState = ACC;
                end
            end
            ACC:     w_nextState = (r_rows == ADDR_ONE) ? DONE : ISSUE;
            DONE:    w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    assign busy         = (r_state != IDLE);
    assign result       = r_result;
    assign result_valid = r_resultValid;
    assign cat_detect   = r_cat;

endmodule

// File: tb/tb_weights_dot_engine.sv
// Randomised self-checking bench for weights_dot_engine with a behavioural
// weights bank and an arithmetic dot-product reference model.
module tb_weights_dot_engine;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [12:0] base_addr;
    logic [12:0] row_count;
    logic        busy;
    logic        pix_valid;
    logic        pix_ready;
    logic [23:0] pix_data;
    logic [1:0]  wb_control;
    logic [12:0] wb_address;
    logic [14:0] wb_read_data;
    logic [31:0] result;
    logic        result_valid;
    logic        cat_detect;

    int compared   = 0;
    int mismatched = 0;

    always #5 clock = ~clock;

    weights_dot_engine dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .base_addr    (base_addr),
        .row_count    (row_count),
        .busy         (busy),
        .pix_valid    (pix_valid),
        .pix_ready    (pix_ready),
        .pix_data     (pix_data),
        .wb_control   (wb_control),
        .wb_address   (wb_address),
        .wb_read_data (wb_read_data),
        .result       (result),
        .result_valid (result_valid),
        .cat_detect   (cat_detect)
    );

    // Bank model: row registered on the READ edge, valid for one cycle only.
    logic [14:0] bankMem [0:8191];
    logic [14:0] bankReg;
    logic        bankValid = 1'b0;
    int          readCount = 0;
    logic [12:0] readAddrQ [$];
    logic [23:0] pixPlan [$];

    always @(posedge clock) begin
        if (wb_control == 2'b10) begin
            bankReg   <= bankMem[wb_address];
            bankValid <= 1'b1;
            readCount <= readCount + 1;
            readAddrQ.push_back(wb_address);
        end else begin
            bankValid <= 1'b0;
        end
    end

    assign wb_read_data = bankValid ? bankReg : 15'bz;

    function automatic logic [31:0] modelDot(input logic [12:0] base, input int cnt);
        int acc = 0;
        for (int r = 0; r < cnt; r++) begin
            int addr   = (int'(base) + r) % 8192;
            int rowVal = int'(bankMem[addr]);
            int pixVal = int'(pixPlan[r]);
            for (int k = 0; k < 3; k++) begin
                int w = (rowVal >> (5*k)) & 31;
                int p = (pixVal >> (8*k)) & 255;
                if (w >= 16) w = w - 32;
                acc = acc + w * p;
            end
        end
        return acc;
    endfunction

    // Runs one job, feeding pixPlan beats with an optional stall before each.
    task automatic runJob(input logic [12:0] base, input logic [12:0] cnt,
                          input int stall, input int spuriousAt,
                          output logic [31:0] res, output logic cat,
                          output int lat, output int vldCycles,
                          output int stallReady, output int reads,
                          output int qStart, output bit timedOut);
        int  cyc;
        int  rowIdx;
        int  stallLeft;
        int  rc0;
        bit  seen;
        res = '0; cat = 1'b0; lat = -1; vldCycles = 0; stallReady = 0;
        timedOut = 1'b0; rowIdx = 0; stallLeft = stall; seen = 1'b0;
        @(negedge clock);
        rc0 = readCount;
        qStart = readAddrQ.size();
        start = 1'b1; base_addr = base; row_count = cnt;
        @(negedge clock);
        start = 1'b0; base_addr = 13'($urandom); row_count = 13'($urandom);
        cyc = 1;
        forever begin
            if (result_valid) begin
                if (!seen) begin
                    seen = 1'b1; lat = cyc; res = result; cat = cat_detect;
                end
                vldCycles++;
            end else if (seen) begin
                break;
            end
            if (cyc > 2000) begin
                timedOut = 1'b1;
                break;
            end
            start     = (cyc == spuriousAt);
            pix_valid = 1'b0;
            pix_data  = 24'($urandom);
            if (pix_ready) begin
                if (stallLeft > 0) begin
                    stallLeft--;
                    stallReady++;
                end else if (rowIdx < pixPlan.size()) begin
                    pix_valid = 1'b1;
                    pix_data  = pixPlan[rowIdx];
                    rowIdx++;
                    stallLeft = stall;
                end
            end
            @(negedge clock);
            cyc++;
        end
        start = 1'b0;
        pix_valid = 1'b0;
        reads = readCount - rc0;
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; pix_valid = 1'b0;
        base_addr = '0; row_count = '0; pix_data = '0;
        repeat (3) @(negedge clock);
        compared += 7;
        if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        if (pix_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_pix_ready: got %b expected 0", pix_ready); end
        if (wb_control !== 2'b00) begin mismatched++; $display("[TB] FAIL reset_wb_control: got %b expected 00", wb_control); end
        if (wb_address !== 13'h0) begin mismatched++; $display("[TB] FAIL reset_wb_address: got %h expected 0", wb_address); end
        if (result !== 32'h0) begin mismatched++; $display("[TB] FAIL reset_result: got %h expected 0", result); end
        if (result_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_result_valid: got %b expected 0", result_valid); end
        if (cat_detect !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_cat: got %b expected 0", cat_detect); end
        reset = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_single_row();
        logic [31:0] res; logic cat; int lat, vld, sr, rd, q0; bit to;
        bankMem[0] = 15'h07C3;
        pixPlan.delete();
        pixPlan.push_back(24'h1E140A);
        runJob(13'h0, 13'd1, 0, -1, res, cat, lat, vld, sr, rd, q0, to);
        compared += 7;
        if (to) begin mismatched++; $display("[TB] FAIL single_timeout: got timeout expected result_valid"); end
        if (res !== 32'd20) begin mismatched++; $display("[TB] FAIL single_result: got %0d expected 20", $signed(res)); end
        if (cat !== 1'b1) begin mismatched++; $display("[TB] FAIL single_cat: got %b expected 1", cat); end
        if (lat != 6) begin mismatched++; $display("[TB] FAIL single_latency: got %0d expected 6", lat); end
        if (vld != 1) begin mismatched++; $display("[TB] FAIL single_valid_width: got %0d expected 1", vld); end
        if (rd != 1) begin mismatched++; $display("[TB] FAIL single_reads: got %0d expected 1", rd); end
        if (readAddrQ.size() <= q0 || readAddrQ[q0] !== 13'h0) begin
            mismatched++; $display("[TB] FAIL single_addr: got other expected 0");
        end
    endtask

    task automatic test_zero_count();
        logic [31:0] res; logic cat; int lat, vld, sr, rd, q0; bit to;
        pixPlan.delete();
        runJob(13'h0100, 13'd0, 0, -1, res, cat, lat, vld, sr, rd, q0, to);
        compared += 5;
        if (to) begin mismatched++; $display("[TB] FAIL zero_timeout: got timeout expected result_valid"); end
        if (res !== 32'h0) begin mismatched++; $display("[TB] FAIL zero_result: got %h expected 0", res); end
        if (cat !== 1'b0) begin mismatched++; $display("[TB] FAIL zero_cat: got %b expected 0", cat); end
        if (lat != 2) begin mismatched++; $display("[TB] FAIL zero_latency: got %0d expected 2", lat); end
        if (rd != 0) begin mismatched++; $display("[TB] FAIL zero_reads: got %0d expected 0", rd); end
    endtask

    task automatic test_addr_wrap();
        logic [31:0] res, exp; logic cat; int lat, vld, sr, rd, q0; bit to;
        pixPlan.delete();
        for (int i = 0; i < 3; i++) pixPlan.push_back(24'($urandom));
        exp = modelDot(13'h1FFE, 3);
        runJob(13'h1FFE, 13'd3, 0, -1, res, cat, lat, vld, sr, rd, q0, to);
        compared += 4;
        if (to) begin mismatched++; $display("[TB] FAIL wrap_timeout: got timeout expected result_valid"); end
        if (res !== exp) begin mismatched++; $display("[TB] FAIL wrap_result: got %h expected %h", res, exp); end
        if (rd != 3) begin mismatched++; $display("[TB] FAIL wrap_reads: got %0d expected 3", rd); end
        if (lat != 14) begin mismatched++; $display("[TB] FAIL wrap_latency: got %0d expected 14", lat); end
        for (int i = 0; i < 3; i++) begin
            int e = (8190 + i) % 8192;
            compared++;
            if (readAddrQ.size() <= q0 + i || int'(readAddrQ[q0+i]) != e) begin
                mismatched++; $display("[TB] FAIL wrap_addr%0d: got other expected %h", i, e);
            end
        end
    endtask

    task automatic test_negative_extreme();
        logic [31:0] res; logic cat; int lat, vld, sr, rd, q0; bit to;
        bankMem[13'h0ABC] = 15'h4210;
        pixPlan.delete();
        pixPlan.push_back(24'hFFFFFF);
        runJob(13'h0ABC, 13'd1, 0, -1, res, cat, lat, vld, sr, rd, q0, to);
        compared += 3;
        if (to) begin mismatched++; $display("[TB] FAIL neg_timeout: got timeout expected result_valid"); end
        if (res !== 32'hFFFFD030) begin mismatched++; $display("[TB] FAIL neg_result: got %h expected FFFFD030", res); end
        if (cat !== 1'b0) begin mismatched++; $display("[TB] FAIL neg_cat: got %b expected 0", cat); end
    endtask

    task automatic test_stall();
        logic [31:0] resA, resB, exp; logic cat; int lat, vld, sr, rd, q0; bit to;
        logic [12:0] base;
        base = 13'($urandom);
        pixPlan.delete();
        for (int i = 0; i < 2; i++) pixPlan.push_back(24'($urandom));
        exp = modelDot(base, 2);
        runJob(base, 13'd2, 0, -1, resA, cat, lat, vld, sr, rd, q0, to);
        compared += 2;
        if (to) begin mismatched++; $display("[TB] FAIL nostall_timeout: got timeout expected result_valid"); end
        if (resA !== exp) begin mismatched++; $display("[TB] FAIL nostall_result: got %h expected %h", resA, exp); end
        runJob(base, 13'd2, 7, -1, resB, cat, lat, vld, sr, rd, q0, to);
        compared += 4;
        if (to) begin mismatched++; $display("[TB] FAIL stall_timeout: got timeout expected result_valid"); end
        if (resB !== exp) begin mismatched++; $display("[TB] FAIL stall_result: got %h expected %h", resB, exp); end
        if (sr != 14) begin mismatched++; $display("[TB] FAIL stall_ready_held: got %0d expected 14", sr); end
        if (lat != 24) begin mismatched++; $display("[TB] FAIL stall_latency: got %0d expected 24", lat); end
    endtask

    task automatic test_busy_start();
        logic [31:0] res, exp; logic cat; int lat, vld, sr, rd, q0; bit to;
        logic [12:0] base;
        base = 13'($urandom);
        pixPlan.delete();
        for (int i = 0; i < 3; i++) pixPlan.push_back(24'($urandom));
        exp = modelDot(base, 3);
        runJob(base, 13'd3, 0, 4, res, cat, lat, vld, sr, rd, q0, to);
        compared += 4;
        if (to) begin mismatched++; $display("[TB] FAIL busy_timeout: got timeout expected result_valid"); end
        if (res !== exp) begin mismatched++; $display("[TB] FAIL busy_result: got %h expected %h", res, exp); end
        if (rd != 3) begin mismatched++; $display("[TB] FAIL busy_reads: got %0d expected 3", rd); end
        if (lat != 14) begin mismatched++; $display("[TB] FAIL busy_latency: got %0d expected 14", lat); end
    endtask

    task automatic test_random_jobs();
        logic [31:0] res, exp; logic cat, expCat; int lat, vld, sr, rd, q0; bit to;
        logic [12:0] base;
        int cnt, stall;
        for (int j = 0; j < 8; j++) begin
            base  = 13'($urandom);
            cnt   = $urandom_range(1, 6);
            stall = $urandom_range(0, 3);
            pixPlan.delete();
            for (int i = 0; i < cnt; i++) pixPlan.push_back(24'($urandom));
            exp    = modelDot(base, cnt);
            expCat = ($signed(exp) > 0);
            runJob(base, 13'(cnt), stall, -1, res, cat, lat, vld, sr, rd, q0, to);
            compared += 4;
            if (to) begin mismatched++; $display("[TB] FAIL rand%0d_timeout: got timeout expected result_valid", j); end
            if (res !== exp) begin mismatched++; $display("[TB] FAIL rand%0d_result: got %h expected %h", j, res, exp); end
            if (cat !== expCat) begin mismatched++; $display("[TB] FAIL rand%0d_cat: got %b expected %b", j, cat, expCat); end
            if (lat != 4*cnt + 2 + stall*cnt) begin
                mismatched++; $display("[TB] FAIL rand%0d_latency: got %0d expected %0d", j, lat, 4*cnt + 2 + stall*cnt);
            end
        end
    endtask

    task automatic test_reset_midop();
        logic [31:0] res, exp; logic cat; int lat, vld, sr, rd, q0; bit to;
        int  pixSeen;
        bit  hit;
        logic [12:0] base;
        pixSeen = 0; hit = 1'b0;
        @(negedge clock);
        start = 1'b1; base_addr = 13'($urandom); row_count = 13'd4;
        @(negedge clock);
        start = 1'b0;
        for (int c = 0; c < 100 && !hit; c++) begin
            pix_valid = 1'b0;
            if (pix_ready) begin
                pixSeen++;
                if (pixSeen == 2) hit = 1'b1;
                else begin pix_valid = 1'b1; pix_data = 24'($urandom); end
            end
            if (!hit) @(negedge clock);
        end
        compared++;
        if (!hit) begin mismatched++; $display("[TB] FAIL midop_reach_row2: got no PIX expected PIX of row 2"); end
        reset = 1'b0;
        #1;
        compared += 6;
        if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL midop_busy: got %b expected 0", busy); end
        if (pix_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL midop_pix_ready: got %b expected 0", pix_ready); end
        if (wb_control !== 2'b00) begin mismatched++; $display("[TB] FAIL midop_wb_control: got %b expected 00", wb_control); end
        if (result !== 32'h0) begin mismatched++; $display("[TB] FAIL midop_result: got %h expected 0", result); end
        if (result_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL midop_valid: got %b expected 0", result_valid); end
        if (cat_detect !== 1'b0) begin mismatched++; $display("[TB] FAIL midop_cat: got %b expected 0", cat_detect); end
        @(negedge clock);
        reset = 1'b1;
        base = 13'($urandom);
        pixPlan.delete();
        pixPlan.push_back(24'($urandom));
        exp = modelDot(base, 1);
        runJob(base, 13'd1, 0, -1, res, cat, lat, vld, sr, rd, q0, to);
        compared += 2;
        if (to) begin mismatched++; $display("[TB] FAIL postreset_timeout: got timeout expected result_valid"); end
        if (res !== exp) begin mismatched++; $display("[TB] FAIL postreset_result: got %h expected %h", res, exp); end
    endtask

    initial begin
        for (int i = 0; i < 8192; i++) bankMem[i] = 15'($urandom);
        test_reset();
        test_single_row();
        test_zero_count();
        test_addr_wrap();
        test_negative_extreme();
        test_stall();
        test_busy_start();
        test_random_jobs();
        test_reset_midop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got no completion expected finish before 1ms");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
